// File: rtl/reg_file_sb.sv
// reg_file_sb: parametrised 1W/2R register file with hardwired zero, write bypass
// and a per-register busy scoreboard that produces the decode issue stall.
module reg_file_sb #(
   parameter int XLEN = 32,
   parameter int NREGS = 32,
   parameter bit ZERO_REG = 1'b1,
   parameter bit BYPASS = 1'b1,
   localparam int AW = $clog2(NREGS)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            wren,
   input  logic [AW-1:0]   rd_addr,
   input  logic [XLEN-1:0] wr_data,
   input  logic [AW-1:0]   rs_addr1,
   input  logic [AW-1:0]   rs_addr2,
   output logic [XLEN-1:0] rs_data1,
   output logic [XLEN-1:0] rs_data2,
   input  logic            issue_valid,
   input  logic [AW-1:0]   issue_rd,
   input  logic            issue_we,
   output logic            stall,
   output logic [AW:0]     busy_cnt
);
   logic [XLEN-1:0] r_rf [NREGS];
   logic [NREGS-1:0] r_busy;
   logic [NREGS-1:0] w_eff_busy;
   logic [AW:0] r_busy_cnt;
   logic w_wr_ok, w_accept, w_set, w_inc, w_dec;
   assign w_wr_ok = wren && !(ZERO_REG && rd_addr == '0);
   always_ff @(posedge clk or negedge rst)
      if (!rst)
         for (int i = 0; i < NREGS; i++) r_rf[i] <= '0;
      else if (w_wr_ok)
         r_rf[rd_addr] <= wr_data;
   assign rs_data1 = (!rst || (ZERO_REG && rs_addr1 == '0)) ? '0 :
                     (BYPASS && wren && rd_addr == rs_addr1) ? wr_data : r_rf[rs_addr1];
   assign rs_data2 = (!rst || (ZERO_REG && rs_addr2 == '0)) ? '0 :
                     (BYPASS && wren && rd_addr == rs_addr2) ? wr_data : r_rf[rs_addr2];
   // A writeback in this cycle already satisfies the hazard only when it is forwarded.
   for (genvar g = 0; g < NREGS; g++) begin : g_eff
      assign w_eff_busy[g] = (ZERO_REG && g == 0) ? 1'b0 :
                             r_busy[g] & ~(BYPASS & wren & (rd_addr == AW'(g)));
   end
   assign stall = rst & issue_valid &
                  (w_eff_busy[rs_addr1] | w_eff_busy[rs_addr2] | (issue_we & w_eff_busy[issue_rd]));
   assign w_accept = issue_valid & ~stall;
   assign w_set = w_accept & issue_we & ~(ZERO_REG && issue_rd == '0);
   assign w_inc = w_set & ~r_busy[issue_rd];
   assign w_dec = wren & r_busy[rd_addr] & ~(w_set & (issue_rd == rd_addr));
   // The issue set is written last so a same-register writeback cannot erase the new producer.
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         r_busy <= '0;
         r_busy_cnt <= '0;
      end else begin
         if (wren) r_busy[rd_addr] <= 1'b0;
         if (w_set) r_busy[issue_rd] <= 1'b1;
         r_busy_cnt <= r_busy_cnt + (AW+1)'(w_inc) - (AW+1)'(w_dec);
      end
   assign busy_cnt = r_busy_cnt;
   a_cnt_matches: assert property (@(posedge clk) disable iff (!rst)
      int'(r_busy_cnt) == $countones(r_busy));
   a_zero_idle: assert property (@(posedge clk) disable iff (!rst)
      !(ZERO_REG && r_busy[0]));
endmodule

// File: tb/tb_reg_file_sb.sv
// tb_reg_file_sb: runs a bypassing and a non-bypassing reg_file_sb side by side
// against a register/busy-set model, with directed literal checks on top.
module tb_reg_file_sb;
   logic clk = 1'b0, rst = 1'b1, wren = 1'b0, issue_valid = 1'b0, issue_we = 1'b0;
   logic [4:0] rd_addr = '0, rs_addr1 = '0, rs_addr2 = '0, issue_rd = '0;
   logic [31:0] wr_data = '0;
   logic [31:0] d1_b, d2_b, d1_n, d2_n;
   logic st_b, st_n;
   logic [5:0] c_b, c_n;
   int n_chk = 0, n_fail = 0;
   bit [31:0] mrf [32];
   bit mb [2][32];

   reg_file_sb #(.XLEN(32), .NREGS(32), .ZERO_REG(1'b1), .BYPASS(1'b1)) u_b (
      .clk(clk), .rst(rst), .wren(wren), .rd_addr(rd_addr), .wr_data(wr_data),
      .rs_addr1(rs_addr1), .rs_addr2(rs_addr2), .rs_data1(d1_b), .rs_data2(d2_b),
      .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_we(issue_we),
      .stall(st_b), .busy_cnt(c_b));
   reg_file_sb #(.XLEN(32), .NREGS(32), .ZERO_REG(1'b1), .BYPASS(1'b0)) u_n (
      .clk(clk), .rst(rst), .wren(wren), .rd_addr(rd_addr), .wr_data(wr_data),
      .rs_addr1(rs_addr1), .rs_addr2(rs_addr2), .rs_data1(d1_n), .rs_data2(d2_n),
      .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_we(issue_we),
      .stall(st_n), .busy_cnt(c_n));

   always #5 clk = ~clk;

   // Model: v=1 is the bypassing instance, v=0 the non-bypassing one.
   function automatic bit m_eff(int v, logic [4:0] x);
      return mb[v][x] && !(v == 1 && wren && rd_addr == x);
   endfunction
   function automatic bit m_stall(int v);
      return rst && issue_valid &&
             (m_eff(v, rs_addr1) || m_eff(v, rs_addr2) || (issue_we && m_eff(v, issue_rd)));
   endfunction
   function automatic logic [31:0] m_rd(int v, logic [4:0] a);
      if (!rst || a == 0) return 32'h0;
      if (v == 1 && wren && rd_addr == a) return wr_data;
      return mrf[a];
   endfunction
   function automatic int m_cnt(int v);
      int n = 0;
      for (int i = 0; i < 32; i++) n += int'(mb[v][i]);
      return n;
   endfunction

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < 32; i++) begin
            mrf[i] <= '0;
            mb[0][i] <= 1'b0;
            mb[1][i] <= 1'b0;
         end
      end else begin
         if (wren && rd_addr != 0) mrf[rd_addr] <= wr_data;
         for (int v = 0; v < 2; v++) begin
            if (wren) mb[v][rd_addr] <= 1'b0;
            if (issue_valid && issue_we && issue_rd != 0 && !m_stall(v)) mb[v][issue_rd] <= 1'b1;
         end
      end
   end

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      chk("m_b_rs1", d1_b, m_rd(1, rs_addr1));
      chk("m_b_rs2", d2_b, m_rd(1, rs_addr2));
      chk("m_b_stall", 32'(st_b), 32'(m_stall(1)));
      chk("m_b_cnt", 32'(c_b), 32'(m_cnt(1)));
      chk("m_n_rs1", d1_n, m_rd(0, rs_addr1));
      chk("m_n_rs2", d2_n, m_rd(0, rs_addr2));
      chk("m_n_stall", 32'(st_n), 32'(m_stall(0)));
      chk("m_n_cnt", 32'(c_n), 32'(m_cnt(0)));
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #2 rst = 1'b0;
      #10 rst = 1'b1;
      cyc();
      // reset: r5 written and r6 busy, then a mid-cycle reset wipes both
      wren = 1'b1; rd_addr = 5'd5; wr_data = 32'hDEADBEEF;
      issue_valid = 1'b1; issue_we = 1'b1; issue_rd = 5'd6;
      cyc();
      wren = 1'b0; issue_we = 1'b0; issue_rd = 5'd0; rs_addr1 = 5'd6; rs_addr2 = 5'd5;
      #2;
      chk("pre_rst_rd_b", d2_b, 32'hDEADBEEF);
      chk("pre_rst_stall_b", 32'(st_b), 32'd1);
      chk("pre_rst_cnt_n", 32'(c_n), 32'd1);
      rst = 1'b0;
      #1;
      chk("rst_rd_b", d2_b, 32'h0);
      chk("rst_rd_n", d2_n, 32'h0);
      chk("rst_stall_b", 32'(st_b), 32'd0);
      chk("rst_cnt_b", 32'(c_b), 32'd0);
      cyc();
      rst = 1'b1; issue_valid = 1'b0;
      #2;
      chk("post_rst_rd_n", d2_n, 32'h0);
      chk("post_rst_cnt_n", 32'(c_n), 32'd0);
      // zero register
      wren = 1'b1; rd_addr = 5'd0; wr_data = 32'h1234; rs_addr1 = 5'd0; rs_addr2 = 5'd0;
      issue_valid = 1'b1; issue_we = 1'b1; issue_rd = 5'd0;
      #2;
      chk("zero_rd_b", d1_b, 32'h0);
      chk("zero_stall_n", 32'(st_n), 32'd0);
      cyc();
      wren = 1'b0; issue_valid = 1'b0; issue_we = 1'b0;
      #2;
      chk("zero_cnt_b", 32'(c_b), 32'd0);
      chk("zero_rd_n", d1_n, 32'h0);
      // bypass
      wren = 1'b1; rd_addr = 5'd7; wr_data = 32'hA5A5A5A5; rs_addr1 = 5'd7; rs_addr2 = 5'd7;
      #2;
      chk("byp_rs1_b", d1_b, 32'hA5A5A5A5);
      chk("byp_rs2_b", d2_b, 32'hA5A5A5A5);
      chk("byp_rs1_n", d1_n, 32'h0);
      chk("byp_rs2_n", d2_n, 32'h0);
      cyc();
      wren = 1'b0;
      #2;
      chk("byp_next_n", d1_n, 32'hA5A5A5A5);
      // RAW stall on r3
      rs_addr1 = 5'd0; rs_addr2 = 5'd0;
      issue_valid = 1'b1; issue_we = 1'b1; issue_rd = 5'd3;
      cyc();
      issue_we = 1'b0; issue_rd = 5'd0; rs_addr1 = 5'd3;
      #2;
      chk("raw_stall_b", 32'(st_b), 32'd1);
      chk("raw_stall_n", 32'(st_n), 32'd1);
      chk("raw_cnt_b", 32'(c_b), 32'd1);
      cyc();
      chk("raw_hold_n", 32'(st_n), 32'd1);
      wren = 1'b1; rd_addr = 5'd3; wr_data = 32'h33;
      #2;
      chk("raw_wb_stall_b", 32'(st_b), 32'd0);
      chk("raw_wb_stall_n", 32'(st_n), 32'd1);
      cyc();
      wren = 1'b0;
      #2;
      chk("raw_after_n", 32'(st_n), 32'd0);
      chk("raw_after_cnt_n", 32'(c_n), 32'd0);
      chk("raw_after_rd_n", d1_n, 32'h33);
      // simultaneous set/clear of r9
      rs_addr1 = 5'd0; issue_we = 1'b1; issue_rd = 5'd9;
      cyc();
      wren = 1'b1; rd_addr = 5'd9; wr_data = 32'h99;
      #2;
      chk("sc_stall_b", 32'(st_b), 32'd0);
      chk("sc_stall_n", 32'(st_n), 32'd1);
      cyc();
      wren = 1'b0; issue_valid = 1'b0; issue_we = 1'b0;
      #2;
      chk("sc_cnt_b", 32'(c_b), 32'd1);
      chk("sc_cnt_n", 32'(c_n), 32'd0);
      wren = 1'b1; rd_addr = 5'd9;
      cyc();
      wren = 1'b0;
      #2;
      chk("sc_clr_cnt_b", 32'(c_b), 32'd0);
      // fill all nonzero registers, then drain
      issue_valid = 1'b1; issue_we = 1'b1;
      for (int i = 1; i < 32; i++) begin
         issue_rd = 5'(i);
         cyc();
      end
      issue_rd = 5'd4;
      #2;
      chk("fill_cnt_b", 32'(c_b), 32'd31);
      chk("fill_cnt_n", 32'(c_n), 32'd31);
      chk("fill_waw_b", 32'(st_b), 32'd1);
      chk("model_fill_cnt", 32'(m_cnt(1)), 32'd31);
      issue_valid = 1'b0; issue_we = 1'b0;
      for (int i = 1; i < 32; i++) begin
         wren = 1'b1; rd_addr = 5'(i); wr_data = 32'(i * 3);
         cyc();
      end
      wren = 1'b0; rs_addr1 = 5'd31;
      #2;
      chk("drain_cnt_b", 32'(c_b), 32'd0);
      chk("drain_cnt_n", 32'(c_n), 32'd0);
      chk("drain_rd_n", d1_n, 32'd93);
      chk("model_drain_cnt", 32'(m_cnt(0)), 32'd0);
      cyc();
      cyc();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
